// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M decode constants and sequencer FSM state encoding.
package muldiv_sequencer_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers, one shift-add or restoring-divide step per cycle,
// and sign correction / special-case forcing of the final result.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_finish,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic              r_special;
  logic [XLEN-1:0]   r_spec_val;
  logic [XLEN-1:0]   r_result;

  logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;

  assign w_a_signed = (i_funct3 == F3_MULH) | (i_funct3 == F3_MULHSU) |
                      (i_funct3 == F3_DIV)  | (i_funct3 == F3_REM);
  assign w_b_signed = (i_funct3 == F3_MULH) | (i_funct3 == F3_DIV) | (i_funct3 == F3_REM);
  assign w_a_neg    = w_a_signed & i_rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & i_rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_rs1 : i_rs1;
  assign w_b_mag    = w_b_neg ? -i_rs2 : i_rs2;
  // Remainder follows the dividend sign; everything else is the product of signs.
  assign w_neg      = (i_funct3[2] & i_funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_ovf      = ~i_funct3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (i_rs2 == '1);

  always_comb begin
    w_special  = 1'b0;
    w_spec_val = '0;
    if (!i_funct3[2]) begin
      w_special = (i_rs1 == '0) | (i_rs2 == '0);
    end else if (i_rs2 == '0) begin
      w_special  = 1'b1;
      w_spec_val = i_funct3[1] ? i_rs1 : '1;
    end else if (w_ovf) begin
      w_special  = 1'b1;
      w_spec_val = i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  assign o_special = w_special;

  logic [XLEN:0]     w_sum, w_shift, w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem;
  logic [2*XLEN-1:0] w_acc_next, w_fin, w_prod;
  logic [XLEN-1:0]   w_lo_s, w_hi_s, w_calc;

  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

  assign w_acc_next = r_f3[2] ? {w_rem, r_acc[XLEN-2:0], w_ge} : {w_sum, r_acc[XLEN-1:1]};
  // The final step and the result capture share one edge.
  assign w_fin      = i_step ? w_acc_next : r_acc;
  assign w_prod     = r_neg ? -w_fin : w_fin;
  assign w_lo_s     = r_neg ? -w_fin[XLEN-1:0] : w_fin[XLEN-1:0];
  assign w_hi_s     = r_neg ? -w_fin[2*XLEN-1:XLEN] : w_fin[2*XLEN-1:XLEN];

  always_comb begin
    w_calc = '0;
    unique case (r_f3)
      F3_MUL:                       w_calc = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_calc = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_calc = w_lo_s;
      F3_REM, F3_REMU:              w_calc = w_hi_s;
      default:                      w_calc = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_b        <= '0;
      r_f3       <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_result   <= '0;
    end else begin
      if (i_load) begin
        r_acc      <= {{XLEN{1'b0}}, w_a_mag};
        r_b        <= w_b_mag;
        r_f3       <= i_funct3;
        r_neg      <= w_neg;
        r_special  <= w_special;
        r_spec_val <= w_spec_val;
      end else if (i_step) begin
        r_acc <= w_acc_next;
      end
      if (i_finish) begin
        r_result <= i_load ? w_spec_val : (r_special ? r_spec_val : w_calc);
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide sequencer: decode, FSM, counter, stall and flush.
// Define MULDIV_FAST_SPECIAL_EN to finish special-case operands in one cycle.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction_in,
  input  logic            op_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            stall_out,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  state_e     r_state;
  logic [5:0] r_count;
  logic       r_result_valid;
  logic       r_busy;

  logic w_is_m, w_load, w_step, w_last, w_finish, w_special;
  logic w_unused_instr;

  assign w_is_m = op_valid & (instruction_in[6:0] == OPC_OP) &
                  (instruction_in[31:25] == F7_MULDIV);
  assign w_unused_instr = ^{instruction_in[24:15], instruction_in[11:7], w_special};

  assign w_load = (r_state == StIdle) & w_is_m & ~flush;
  assign w_step = (r_state == StBusy) & ~flush;
  assign w_last = (r_state == StBusy) & (r_count == 6'(XLEN-1));
`ifdef MULDIV_FAST_SPECIAL_EN
  assign w_finish = (w_last & ~flush) | (w_load & w_special);
`else
  assign w_finish = w_last & ~flush;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_count        <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (flush) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_is_m) begin
              r_count <= '0;
              r_busy  <= 1'b1;
`ifdef MULDIV_FAST_SPECIAL_EN
              if (w_special) begin
                r_state        <= StDone;
                r_result_valid <= 1'b1;
              end else begin
                r_state <= StBusy;
              end
`else
              r_state <= StBusy;
`endif
            end
          end
          StBusy: begin
            r_count <= r_count + 6'd1;
            if (w_last) begin
              r_state        <= StDone;
              r_result_valid <= 1'b1;
            end
          end
          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_finish (w_finish),
    .i_funct3 (instruction_in[14:12]),
    .i_rs1    (rs1_val),
    .i_rs2    (rs2_val),
    .o_special(w_special),
    .o_result (result)
  );

  assign stall_out    = w_is_m & ~flush & (r_state != StDone);
  assign result_valid = r_result_valid & ~flush;
  assign busy         = r_busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, latency/stall, flush, reset.
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_in = '0;
  logic        op_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        stall_out;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instruction_in(instruction_in),
    .op_valid      (op_valid),
    .flush         (flush),
    .rs1_val       (rs1_val),
    .rs2_val       (rs2_val),
    .stall_out     (stall_out),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          spec;
  } vec_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_instr(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Monitor: every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected result_valid", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check({e.name, " result"}, result, e.exp);
      end
    end
  end

  task automatic issue(input vec_t v);
    int lat_exp;
    int lat;
    int stalls;
    lat_exp = (FAST && v.spec) ? 1 : 33;
    lat     = -1;
    stalls  = 0;
    sb_q.push_back('{name: v.name, exp: v.exp});
    @(posedge clk);
    #1;
    instruction_in = m_instr(v.f3);
    rs1_val        = v.a;
    rs2_val        = v.b;
    op_valid       = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = c;
        break;
      end
      if (stall_out) stalls++;
    end
    check({v.name, " latency"}, lat, lat_exp);
    check({v.name, " stall cycles"}, stalls, lat_exp);
    @(posedge clk);
    #1;
    op_valid       = 1'b0;
    instruction_in = '0;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs = '{
      '{"MUL 7*-3",         3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},
      '{"MULHU -1*-1",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
      '{"MULH -1*-1",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
      '{"MULHSU -1*2",      3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0},
      '{"MUL 0*5",          3'b000, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1},
      '{"DIV -7/2",         3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
      '{"REM -7/2",         3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},
      '{"DIV 5/0",          3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1},
      '{"REM 5/0",          3'b110, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1},
      '{"DIV ovf",          3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
      '{"REM ovf",          3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{"DIVU 5/0",         3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1},
      '{"DIVU 100/7",       3'b101, 32'd100,      32'd7,        32'd14,       1'b0},
      '{"REMU 100/7",       3'b111, 32'd100,      32'd7,        32'd2,        1'b0}
    };

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall_out", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);

    // Reset in the middle of a MUL; result still holds the last value (2) beforehand.
    @(posedge clk);
    #1;
    instruction_in = m_instr(3'b000);
    rs1_val        = 32'h00000007;
    rs2_val        = 32'hFFFFFFFD;
    op_valid       = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset result_valid", 32'(result_valid), 32'd0);
    check("mid-op reset result", result, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    op_valid = 1'b0;
    v = '{"MUL after reset", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
    issue(v);

    // Flush a DIV at T+10: no result, IDLE at T+11, following ADD never stalls.
    @(posedge clk);
    #1;
    instruction_in = m_instr(3'b100);
    rs1_val        = 32'd100;
    rs2_val        = 32'd7;
    op_valid       = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush cycle stall_out", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
    flush          = 1'b0;
    instruction_in = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    @(negedge clk);
    check("post-flush busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("ADD stall_out", 32'(stall_out), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("outstanding results", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
